// File: rtl/shift_pkg.sv
// Shared types and constants for the shift datapath stage.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFTING,
    DONE
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;

  // The counter must be able to represent WIDTH itself, the saturation value.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating up-counter with synchronous clear and enable; sat is high at MAX.
module shift_counter #(
  parameter int unsigned MAX  = 4,
  parameter int unsigned CNTW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [CNTW-1:0] cnt,
  output logic            sat
);

  localparam logic [CNTW-1:0] MAXV = CNTW'(MAX);

  assign sat = (cnt == MAXV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/shift_datapath.sv
// Parallel-load / serial-shift register driven by controller strobes, with
// shift counting, over-shift flag and result capture. Option: SHIFT_ROTATE_EN.
module shift_datapath
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNTW  = cnt_width(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LD,
  input  logic             SH,
  input  logic             D,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic [CNTW-1:0]  CNT,
  output logic             BUSY,
  output logic             OVF,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_VALID
);

  state_t state;
  logic   active;
  logic   d_acc;
  logic   sh_acc;
  logic   sat;
  logic   msb_in;

  assign active = (state == LOADED) || (state == SHIFTING);
  assign BUSY   = active;
  assign SOUT   = Q[0];

  // Priority LD > D > SH; D and SH only act while a word is in flight.
  assign d_acc  = !LD && D && active;
  assign sh_acc = !LD && !D && SH && active;

`ifdef SHIFT_ROTATE_EN
  assign msb_in = Q[0];
`else
  assign msb_in = SIN;
`endif

  shift_counter #(
    .MAX  (WIDTH),
    .CNTW (CNTW)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (LD),
    .en    (sh_acc),
    .cnt   (CNT),
    .sat   (sat)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      Q            <= '0;
      OVF          <= 1'b0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
    end else begin
      RESULT_VALID <= d_acc;
      if (LD) begin
        Q     <= DIN;
        OVF   <= 1'b0;
        state <= LOADED;
      end else if (d_acc) begin
        RESULT <= Q;
        state  <= DONE;
      end else if (sh_acc) begin
        if (sat) begin
          OVF <= 1'b1;
        end else begin
          Q     <= {msb_in, Q[WIDTH-1:1]};
          state <= SHIFTING;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule
